store_unit_s: RTL and testbench
===============================

Name: store_unit_s

Overview:
- Executes RV32I S-type stores (SB/SH/SW, opcode 7'h23). It is the write-side counterpart of the I-type load path.
- Computes rs1 + sign-extended imm12, then writes the 32-bit word RAM port.
- The RAM port has no byte enables, so SB/SH use a read-modify-write sequence. SW is a single write.
- Sits beside the I/R-type units in the datapath. The sequencer pulses iSTART and waits for oDONE.

Parameters:
- OPCODE_S, 7'h23, opcode accepted; other opcodes at iSTART are ignored.
- RAM_RD_LATENCY, 1, cycles oRAM_RD is held before iRAM_DATA is sampled. Legal range is 1..7.

Ports:
- iCLK  in  1  clock, rising edge.
- iRST  in  1  reset, asynchronous, active-high.
- iSTART  in  1  one-cycle request; iIR, iREG_OUT1 and iREG_OUT2 are valid in this cycle.
- iIR  in  32  instruction word.
- oRS1  out  5  iIR[19:15], combinational.
- oRS2  out  5  iIR[24:20], combinational.
- iREG_OUT1  in  32  rs1 value (base address).
- iREG_OUT2  in  32  rs2 value (store data).
- oRAM_CE  out  1  RAM chip enable.
- oRAM_RD  out  1  RAM read strobe.
- oRAM_WR  out  1  RAM write strobe.
- oRAM_ADDR  out  32  word-aligned byte address {ea[31:2],2'b00}.
- oRAM_WDATA  out  32  merged write word.
- iRAM_DATA  in  32  RAM read data.
- oBUSY  out  1  high whenever the state is not IDLE.
- oDONE  out  1  one-cycle completion pulse.
- oMISALIGNED  out  1  one-cycle pulse together with oDONE; only exists when STORE_MISALIGN_TRAP_EN is defined.

Behaviour:
- Reset: state=IDLE; all outputs 0 except the combinational oRS1/oRS2; latched registers 0.
- Reset mid-operation aborts immediately. No write is issued after reset asserts.
- Accept condition: iSTART && state==IDLE && iIR[6:0]==OPCODE_S. iSTART in any other state is ignored (no queueing).
- Latched at accept:
  - ea = iREG_OUT1 + sext({iIR[31:25],iIR[11:7]}), 32-bit modular; wrap at 2^32 is legal.
  - wdata = iREG_OUT2.
  - func3 = iIR[14:12].
- States:
  - IDLE -> WRITE when func3==SW.
  - IDLE -> READ when func3 is SB or SH.
  - IDLE -> DONE when func3 is illegal (3..7): no RAM access, oDONE pulses.
  - READ: oRAM_CE=1, oRAM_RD=1, oRAM_ADDR valid, held for RAM_RD_LATENCY cycles via a down-counter. On the edge where the counter reaches 0, capture iRAM_DATA -> rdata, then go to WRITE.
  - WRITE: one cycle with oRAM_CE=1, oRAM_WR=1, oRAM_ADDR and oRAM_WDATA valid -> DONE.
  - DONE: oDONE=1 for one cycle -> IDLE.
- Write data merge:
  - SW: wdata.
  - SB: rdata with byte lane ea[1:0] replaced by wdata[7:0].
  - SH: rdata with half lane ea[1] replaced by wdata[15:0].
- Latency from the accept edge to the oDONE cycle:
  - SW: 2 cycles.
  - SB/SH: RAM_RD_LATENCY+2 cycles.
- oRAM_RD and oRAM_WR are never high in the same cycle.
- oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR, oRAM_WDATA and oDONE are driven only from the state register and latched registers, never from inputs.

Optional Feature:
- Macro STORE_MISALIGN_TRAP_EN.
- Defined:
  - Misalignment is SH with ea[0]=1, or SW with ea[1:0]!=0.
  - A misaligned store goes IDLE -> DONE with no RAM access.
  - oMISALIGNED=1 in the same cycle as oDONE.
- Undefined:
  - The low address bits are silently ignored: SW writes the aligned word; SH uses ea[1] only.
  - The oMISALIGNED port is absent.

Decomposition:
- Shared package:
  - func3 constants F3_SB=0, F3_SH=1, F3_SW=2.
  - OPCODE_S.
  - State enum {IDLE, READ, WRITE, DONE}.
- Sub-module store_lane_merge: purely combinational; (rdata, wdata, func3, ea[1:0]) -> merged word. Reusable by a future byte-enable RAM path.

Test Plan:
- SW: iREG_OUT1=0x100, imm=0xFFC (-4), iREG_OUT2=0xDEADBEEF -> one WRITE cycle with oRAM_ADDR=0xFC, oRAM_WDATA=0xDEADBEEF; oDONE 2 cycles after accept; oRAM_RD never high.
- SB: ea=0x102, rs2=0x000000A5, RAM returns 0x11223344 -> READ at 0x100, then WRITE 0x11A53344.
- SH with RAM_RD_LATENCY=3: ea=0x102, rs2=0x0000BEEF, RAM returns 0x11223344 -> oRAM_RD high for exactly 3 cycles, WRITE 0xBEEF3344, oDONE at cycle 5.
- Misaligned SW, ea=0x101:
  - With the macro: no CE; oDONE=oMISALIGNED=1 one cycle after accept.
  - Without the macro: WRITE to 0x100.
- Reset during READ: assert iRST -> outputs 0 asynchronously; no WRITE cycle; the next iSTART SW completes normally.
- Busy and filtering:
  - iSTART while busy is ignored; exactly one write occurs.
  - Opcode 0x03 with iSTART -> no state change.
  - func3=3 -> oDONE with no RAM access.

Source files
------------

// File: rtl/store_unit_s_pkg.sv
// Shared definitions for the S-type store unit: opcode, func3 encodings, FSM states.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package store_unit_s_pkg;

    localparam logic [6:0] OPCODE_S = 7'h23;

    localparam logic [2:0] F3_SB = 3'd0;
    localparam logic [2:0] F3_SH = 3'd1;
    localparam logic [2:0] F3_SW = 3'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Sign-extend the 12-bit S-type immediate to 32 bits.
    function automatic logic [31:0] sext12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/store_unit_s_lane_merge.sv
// Lane merge: overlays store data onto a read-back word for SB/SH; SW passes data through.
// Latency: purely combinational.
// Backpressure: none.
// Ports: rdata (word read from RAM), wdata (rs2 store data), func3 (store width),
//        ea_lo (effective address bits [1:0]) -> merged (word to write).
module store_lane_merge
    import store_unit_s_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [2:0]  func3,
    input  logic [1:0]  ea_lo,
    output logic [31:0] merged
);

    always_comb begin
        merged = wdata;
        case (func3)
            F3_SB: begin
                merged = rdata;
                merged[{ea_lo, 3'b000} +: 8] = wdata[7:0];
            end
            F3_SH: begin
                merged = rdata;
                // Only ea[1] selects the half; ea[0] never shifts the lane.
                if (ea_lo[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/store_unit_s.sv
// RV32I S-type store unit (SB/SH/SW) for a word RAM without byte enables; SB/SH do read-modify-write.
// Latency: accept edge to oDONE cycle is 2 cycles for SW, RAM_RD_LATENCY+2 for SB/SH, 1 for illegal func3.
// Backpressure: none; iSTART outside IDLE is dropped (no queueing), oBUSY tells the sequencer to wait.
// Ports: iCLK/iRST clock and async active-high reset; iSTART/iIR/iREG_OUT1/iREG_OUT2 request;
//        oRS1/oRS2 register-file read indices; oRAM_* word RAM port with iRAM_DATA read data;
//        oBUSY/oDONE status; oMISALIGNED trap pulse, present only with STORE_MISALIGN_TRAP_EN defined.
// Build option: STORE_MISALIGN_TRAP_EN turns misaligned SH/SW into a no-access trap completion.
module store_unit_s #(
    parameter logic [6:0]  OPCODE_S       = 7'h23,
    parameter int unsigned RAM_RD_LATENCY = 1
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic [31:0] iIR,
    output logic [4:0]  oRS1,
    output logic [4:0]  oRS2,
    input  logic [31:0] iREG_OUT1,
    input  logic [31:0] iREG_OUT2,
    output logic        oRAM_CE,
    output logic        oRAM_RD,
    output logic        oRAM_WR,
    output logic [31:0] oRAM_ADDR,
    output logic [31:0] oRAM_WDATA,
    input  logic [31:0] iRAM_DATA,
    output logic        oBUSY,
`ifdef STORE_MISALIGN_TRAP_EN
    output logic        oDONE,
    output logic        oMISALIGNED
`else
    output logic        oDONE
`endif
);

    import store_unit_s_pkg::*;

    // Counter preload: READ lasts RAM_RD_LATENCY cycles, data captured when it hits zero.
    localparam logic [2:0] RD_CNT_INIT = 3'(RAM_RD_LATENCY - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] ea;
    logic [31:0] wdata;
    logic [2:0]  func3;
    logic [31:0] rdata;
    logic [2:0]  rd_cnt;
    logic [31:0] merged;

    logic        accept;
    logic [31:0] ea_in;
    logic [2:0]  f3_in;
    logic        mis_in;

    assign oRS1 = iIR[19:15];
    assign oRS2 = iIR[24:20];

    assign accept = iSTART && (state == IDLE) && (iIR[6:0] == OPCODE_S);
    assign ea_in  = iREG_OUT1 + sext12({iIR[31:25], iIR[11:7]});
    assign f3_in  = iIR[14:12];

`ifdef STORE_MISALIGN_TRAP_EN
    logic mis_q;
    assign mis_in = ((f3_in == F3_SH) && ea_in[0]) ||
                    ((f3_in == F3_SW) && (ea_in[1:0] != 2'b00));
    assign oMISALIGNED = (state == DONE) && mis_q;
`else
    assign mis_in = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    // Illegal widths and trapped misalignments complete without touching RAM.
                    if ((f3_in > F3_SW) || mis_in) begin
                        state_nxt = DONE;
                    end else if (f3_in == F3_SW) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            READ:    if (rd_cnt == 3'd0) state_nxt = WRITE;
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State and latched operands.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state  <= IDLE;
            ea     <= '0;
            wdata  <= '0;
            func3  <= '0;
            rdata  <= '0;
            rd_cnt <= '0;
`ifdef STORE_MISALIGN_TRAP_EN
            mis_q  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                ea     <= ea_in;
                wdata  <= iREG_OUT2;
                func3  <= f3_in;
                rd_cnt <= RD_CNT_INIT;
`ifdef STORE_MISALIGN_TRAP_EN
                mis_q  <= mis_in;
`endif
            end
            if (state == READ) begin
                if (rd_cnt == 3'd0) begin
                    rdata <= iRAM_DATA;
                end else begin
                    rd_cnt <= rd_cnt - 3'd1;
                end
            end
        end
    end

    store_lane_merge u_merge (
        .rdata  (rdata),
        .wdata  (wdata),
        .func3  (func3),
        .ea_lo  (ea[1:0]),
        .merged (merged)
    );

    // RAM-side outputs decode state and latched registers only, never live inputs.
    assign oRAM_CE    = (state == READ) || (state == WRITE);
    assign oRAM_RD    = (state == READ);
    assign oRAM_WR    = (state == WRITE);
    assign oRAM_ADDR  = oRAM_CE ? {ea[31:2], 2'b00} : 32'd0;
    assign oRAM_WDATA = (state == WRITE) ? merged : 32'd0;
    assign oBUSY      = (state != IDLE);
    assign oDONE      = (state == DONE);

endmodule

// File: tb/tb_store_unit_s.sv
// Scoreboard bench for store_unit_s (RAM_RD_LATENCY=3): directed stores push expected RAM
// traffic and completion records; a negedge monitor checks every RAM cycle and oDONE pulse.
// Build option: STORE_MISALIGN_TRAP_EN selects the trapping expectations.
module tb_store_unit_s;

    localparam int LAT = 3;
    localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] ir = '0, r1 = '0, r2 = '0;
    logic [31:0] ram_data;
    logic [4:0]  rs1_o, rs2_o;
    logic        ce, rd, wr, busy, done;
    logic [31:0] addr, wdat;
`ifdef STORE_MISALIGN_TRAP_EN
    logic        mis;
`endif

    always #5 clk = ~clk;

    store_unit_s #(.OPCODE_S(7'h23), .RAM_RD_LATENCY(LAT)) dut (
        .iCLK(clk), .iRST(rst), .iSTART(start), .iIR(ir),
        .oRS1(rs1_o), .oRS2(rs2_o), .iREG_OUT1(r1), .iREG_OUT2(r2),
        .oRAM_CE(ce), .oRAM_RD(rd), .oRAM_WR(wr), .oRAM_ADDR(addr),
        .oRAM_WDATA(wdat), .iRAM_DATA(ram_data), .oBUSY(busy),
`ifdef STORE_MISALIGN_TRAP_EN
        .oDONE(done), .oMISALIGNED(mis)
`else
        .oDONE(done)
`endif
    );

    typedef struct {
        logic        has_wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          rd_n;
        int          lat;
        logic        mis;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rd_seen = 0;
    int          wr_seen = 0;
    logic [31:0] ram_word = '0;

    // RAM model: real data only in the last cycle of the read window, junk before it.
    assign ram_data = (rd_seen == LAT) ? ram_word : 32'h5A5A5A5A;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic bad(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=event expected=none t=%0t", nm, $time);
    endtask

    function automatic logic [31:0] mk_s(input logic [11:0] imm, input logic [2:0] f3,
                                         input logic [6:0] opc);
        return {imm[11:5], 5'd7, 5'd5, f3, imm[4:0], opc};
    endfunction

    function automatic exp_t mk_e(input logic hw, input logic [31:0] a, input logic [31:0] d,
                                  input int rn, input int lt, input logic m);
        exp_t x;
        x.has_wr = hw; x.addr = a; x.data = d; x.rd_n = rn; x.lat = lt; x.mis = m; x.acc = 0;
        return x;
    endfunction

    // Called at a negedge; request is sampled on the next posedge.
    task automatic issue(input logic [31:0] instr, input logic [31:0] base, input logic [31:0] data,
                         input logic [31:0] rw, input logic push, input exp_t ex);
        exp_t x;
        x = ex;
        ir = instr; r1 = base; r2 = data; start = 1'b1;
        if (push) begin
            ram_word = rw;
            x.acc = cyc + 1;
            q.push_back(x);
        end
        #1;
        chk("rs1_idx", 32'(rs1_o), 32'd5);
        chk("rs2_idx", 32'(rs2_o), 32'd7);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) bad("drain_timeout");
        @(negedge clk);
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            rd_seen = 0;
            wr_seen = 0;
        end else begin
            if (rd) begin
                rd_seen++;
                if (q.size() == 0) bad("unexpected_rd");
                else begin
                    chk("rd_addr", addr, q[0].addr);
                    chk("rd_ce", 32'(ce), 32'd1);
                end
            end
            if (wr) begin
                wr_seen++;
                chk("wr_rd_overlap", 32'(rd), 32'd0);
                if (q.size() == 0) bad("unexpected_wr");
                else begin
                    chk("wr_addr", addr, q[0].addr);
                    chk("wr_data", wdat, q[0].data);
                    chk("wr_ce", 32'(ce), 32'd1);
                end
            end
            if (done) begin
                if (q.size() == 0) bad("unexpected_done");
                else begin
                    e = q.pop_front();
                    chk("done_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    chk("rd_cycles", 32'(rd_seen), 32'(e.rd_n));
                    chk("wr_cycles", 32'(wr_seen), e.has_wr ? 32'd1 : 32'd0);
`ifdef STORE_MISALIGN_TRAP_EN
                    chk("misaligned", 32'(mis), 32'(e.mis));
`endif
                end
                rd_seen = 0;
                wr_seen = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t none;
        none = mk_e(1'b0, 32'd0, 32'd0, 0, 0, 1'b0);

        // Reset state.
        #1;
        chk("rst_ce", 32'(ce), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_wdata", wdat, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // SW with negative immediate: 0x100 + (-4) = 0xFC.
        issue(mk_s(12'hFFC, SW, 7'h23), 32'h100, 32'hDEADBEEF, 32'h0, 1'b1,
              mk_e(1'b1, 32'h0FC, 32'hDEADBEEF, 0, 2, 1'b0));
        drain();
        // SB lane 2.
        issue(mk_s(12'h002, SB, 7'h23), 32'h100, 32'h000000A5, 32'h11223344, 1'b1,
              mk_e(1'b1, 32'h100, 32'h11A53344, LAT, LAT + 2, 1'b0));
        drain();
        // SH upper half.
        issue(mk_s(12'h002, SH, 7'h23), 32'h100, 32'h0000BEEF, 32'h11223344, 1'b1,
              mk_e(1'b1, 32'h100, 32'hBEEF3344, LAT, LAT + 2, 1'b0));
        drain();
        // SB lane 3.
        issue(mk_s(12'h003, SB, 7'h23), 32'h200, 32'h12345677, 32'hAABBCCDD, 1'b1,
              mk_e(1'b1, 32'h200, 32'h77BBCCDD, LAT, LAT + 2, 1'b0));
        drain();
        // SH lower half with address wrap past 2^32.
        issue(mk_s(12'h002, SH, 7'h23), 32'hFFFFFFFE, 32'hCAFE1234, 32'hAABBCCDD, 1'b1,
              mk_e(1'b1, 32'h000, 32'hAABB1234, LAT, LAT + 2, 1'b0));
        drain();
        // SB with imm = -2047 split across both immediate fields: ea = 0x801, lane 1.
        issue(mk_s(12'h801, SB, 7'h23), 32'h1000, 32'h000000EE, 32'h01234567, 1'b1,
              mk_e(1'b1, 32'h800, 32'h0123EE67, LAT, LAT + 2, 1'b0));
        drain();

        // Misaligned SW (ea=0x101) and SH (ea=0x103).
`ifdef STORE_MISALIGN_TRAP_EN
        issue(mk_s(12'h001, SW, 7'h23), 32'h100, 32'h0BADF00D, 32'h0, 1'b1,
              mk_e(1'b0, 32'h0, 32'h0, 0, 1, 1'b1));
        drain();
        issue(mk_s(12'h003, SH, 7'h23), 32'h100, 32'h00005566, 32'h11223344, 1'b1,
              mk_e(1'b0, 32'h0, 32'h0, 0, 1, 1'b1));
        drain();
`else
        issue(mk_s(12'h001, SW, 7'h23), 32'h100, 32'h0BADF00D, 32'h0, 1'b1,
              mk_e(1'b1, 32'h100, 32'h0BADF00D, 0, 2, 1'b0));
        drain();
        issue(mk_s(12'h003, SH, 7'h23), 32'h100, 32'h00005566, 32'h11223344, 1'b1,
              mk_e(1'b1, 32'h100, 32'h55663344, LAT, LAT + 2, 1'b0));
        drain();
`endif

        // Illegal func3=3: done with no RAM access.
        issue(mk_s(12'h000, 3'd3, 7'h23), 32'h100, 32'h12345678, 32'h0, 1'b1,
              mk_e(1'b0, 32'h0, 32'h0, 0, 1, 1'b0));
        drain();

        // Load opcode must not be accepted.
        issue(mk_s(12'h000, SW, 7'h03), 32'h100, 32'h12345678, 32'h0, 1'b0, none);
        chk("opc_filter_busy", 32'(busy), 32'd0);
        drain();

        // iSTART while busy (in WRITE, then in READ) is dropped.
        issue(mk_s(12'h000, SW, 7'h23), 32'h300, 32'h11111111, 32'h0, 1'b1,
              mk_e(1'b1, 32'h300, 32'h11111111, 0, 2, 1'b0));
        issue(mk_s(12'h000, SW, 7'h23), 32'h400, 32'h22222222, 32'h0, 1'b0, none);
        drain();
        issue(mk_s(12'h000, SB, 7'h23), 32'h500, 32'h00000033, 32'h44444444, 1'b1,
              mk_e(1'b1, 32'h500, 32'h44444433, LAT, LAT + 2, 1'b0));
        issue(mk_s(12'h000, SW, 7'h23), 32'h600, 32'h66666666, 32'h0, 1'b0, none);
        drain();

        // Reset during READ: outputs drop at once, no write follows.
        issue(mk_s(12'h000, SB, 7'h23), 32'h100, 32'h000000FF, 32'h11223344, 1'b1,
              mk_e(1'b1, 32'h100, 32'h112233FF, LAT, LAT + 2, 1'b0));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ce", 32'(ce), 32'd0);
        chk("arst_rd", 32'(rd), 32'd0);
        chk("arst_wr", 32'(wr), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_addr", addr, 32'd0);
        q.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        issue(mk_s(12'h004, SW, 7'h23), 32'h700, 32'h77777777, 32'h0, 1'b1,
              mk_e(1'b1, 32'h704, 32'h77777777, 0, 2, 1'b0));
        drain();
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
